// File: rtl/mes_pkg.sv
// rtl/mes_pkg.sv - shared types and helpers for the multi-channel edge synchroniser
package mes_pkg;

  // Per-channel edge selection; bit 0 enables rising, bit 1 enables falling
  typedef enum logic [1:0] {
    EM_OFF  = 2'b00,
    EM_RISE = 2'b01,
    EM_FALL = 2'b10,
    EM_BOTH = 2'b11
  } edge_mode_e;

  // Event port state
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_OFFER = 1'b1
  } state_e;

  // Index width that never collapses to zero bits for a single channel
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/edge_sync_chan.sv
// rtl/edge_sync_chan.sv - one channel: synchroniser, edge detect, pulse, saturating count
module edge_sync_chan
  import mes_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             async_in,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] dec,
  input  logic             clr_ovf,
  output logic             pulse,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   s_last;
  logic                   rise;
  logic                   fall;
  logic                   hit;
  logic                   sat;
  logic [CNT_W-1:0]       base;

  assign s_last = sync[SYNC_STAGES-1];
  assign rise   = s_last & ~prev;
  assign fall   = ~s_last & prev;

  // dec is the amount just handed to the consumer; it never exceeds count
  // because it was snapshotted from count and count only grows until then
  assign base   = count - dec;
  assign sat    = (base == CNT_MAX);

  // Synchroniser chain and previous level; keeps tracking while disarmed so
  // toggles during disable or warm-up never look like edges later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], async_in};
      prev <= s_last;
    end
  end

  // Qualify the raw edges by mode; arm already folds in enable and warm-up
  always_comb begin
    hit = 1'b0;
    if (arm) begin
      case (edge_mode_e'(mode))
        EM_RISE: hit = rise;
        EM_FALL: hit = fall;
        EM_BOTH: hit = rise | fall;
        default: hit = 1'b0;
      endcase
    end
  end

  // Pulse, saturating count (transfer and new edge in the same cycle both
  // apply) and sticky overflow where a new loss wins over a clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse <= 1'b0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      pulse <= hit;
      if (hit && !sat) begin
        count <= base + 1'b1;
      end else begin
        count <= base;
      end
      if (hit && sat) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/multi_edge_sync.sv
// rtl/multi_edge_sync.sv - multi-channel edge synchroniser with round-robin event port
module multi_edge_sync
  import mes_pkg::*;
#(
  parameter  int NCH         = 4,
  parameter  int SYNC_STAGES = 2,
  parameter  int CNT_W       = 8,
  localparam int CLOG2N      = clog2_min1(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NCH-1:0]    async_in,
  input  logic [2*NCH-1:0]  mode,
  output logic [NCH-1:0]    pulse_out,
  output logic              evt_vld,
  input  logic              evt_rdy,
  output logic [CLOG2N-1:0] evt_ch,
  output logic [CNT_W-1:0]  evt_cnt,
  output logic [NCH-1:0]    ovf,
  input  logic [NCH-1:0]    clr_ovf
);

  localparam int                WARM_W   = $clog2(SYNC_STAGES + 2);
  localparam logic [WARM_W-1:0] WARM_END = WARM_W'(SYNC_STAGES + 1);
  localparam logic [CLOG2N:0]   NCH_W    = (CLOG2N + 1)'(NCH);
  localparam logic [CLOG2N-1:0] LAST_CH  = CLOG2N'(NCH - 1);

  logic [WARM_W-1:0] warm_cnt;
  logic              warm_done;
  logic              arm;
  logic              xfer;

  logic [CNT_W-1:0]  chan_cnt [NCH];

  state_e            state;
  state_e            state_n;
  logic [CLOG2N-1:0] rr_ptr;
  logic [CLOG2N-1:0] rr_n;
  logic              vld_n;
  logic [CLOG2N-1:0] ch_n;
  logic [CNT_W-1:0]  cnt_n;

  logic              found;
  logic [CLOG2N-1:0] hit_idx;
  logic [CLOG2N:0]   probe;

  assign warm_done = (warm_cnt == WARM_END);
  assign arm       = en & warm_done;
  assign xfer      = evt_vld & evt_rdy;

  // Warm-up: hold off detection until the sync chain and prev hold real samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warm_cnt <= '0;
    end else if (!warm_done) begin
      warm_cnt <= warm_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    logic [CNT_W-1:0] dec;

    assign dec = (xfer && (evt_ch == CLOG2N'(g))) ? evt_cnt : '0;

    edge_sync_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .arm     (arm),
      .async_in(async_in[g]),
      .mode    (mode[2*g +: 2]),
      .dec     (dec),
      .clr_ovf (clr_ovf[g]),
      .pulse   (pulse_out[g]),
      .count   (chan_cnt[g]),
      .ovf     (ovf[g])
    );
  end

  // Round-robin scan: first channel with pending edges, starting at rr_ptr
  always_comb begin
    found   = 1'b0;
    hit_idx = '0;
    probe   = '0;
    for (int i = 0; i < NCH; i++) begin
      probe = {1'b0, rr_ptr} + (CLOG2N + 1)'(i);
      if (probe >= NCH_W) begin
        probe = probe - NCH_W;
      end
      if (!found && (chan_cnt[probe[CLOG2N-1:0]] != '0)) begin
        found   = 1'b1;
        hit_idx = probe[CLOG2N-1:0];
      end
    end
  end

  // Event FSM state and registered offer outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      rr_ptr  <= '0;
      evt_vld <= 1'b0;
      evt_ch  <= '0;
      evt_cnt <= '0;
    end else begin
      state   <= state_n;
      rr_ptr  <= rr_n;
      evt_vld <= vld_n;
      evt_ch  <= ch_n;
      evt_cnt <= cnt_n;
    end
  end

  // Event FSM next state: snapshot in IDLE, hold the offer stable until taken
  always_comb begin
    state_n = state;
    rr_n    = rr_ptr;
    vld_n   = evt_vld;
    ch_n    = evt_ch;
    cnt_n   = evt_cnt;
    case (state)
      S_IDLE: begin
        if (found) begin
          state_n = S_OFFER;
          vld_n   = 1'b1;
          ch_n    = hit_idx;
          cnt_n   = chan_cnt[hit_idx];
        end
      end
      S_OFFER: begin
        if (evt_rdy) begin
          state_n = S_IDLE;
          vld_n   = 1'b0;
          rr_n    = (evt_ch == LAST_CH) ? '0 : evt_ch + 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        vld_n   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_multi_edge_sync.sv
// tb/tb_multi_edge_sync.sv - randomized and directed bench against a behavioural model
module tb_multi_edge_sync;

  localparam int NCH   = 4;
  localparam int SS    = 2;
  localparam int CNT_W = 3;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [NCH-1:0]   async_in;
  logic [2*NCH-1:0] mode;
  logic [NCH-1:0]   pulse_out;
  logic             evt_vld;
  logic             evt_rdy;
  logic [1:0]       evt_ch;
  logic [CNT_W-1:0] evt_cnt;
  logic [NCH-1:0]   ovf;
  logic [NCH-1:0]   clr_ovf;

  int checks   = 0;
  int failures = 0;

  multi_edge_sync #(.NCH(NCH), .SYNC_STAGES(SS), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .async_in (async_in),
    .mode     (mode),
    .pulse_out(pulse_out),
    .evt_vld  (evt_vld),
    .evt_rdy  (evt_rdy),
    .evt_ch   (evt_ch),
    .evt_cnt  (evt_cnt),
    .ovf      (ovf),
    .clr_ovf  (clr_ovf)
  );

  always #5 clk = ~clk;

  // Model: input levels applied per cycle since reset release, pending edge
  // counts per channel, and the current offer
  logic [NCH-1:0]   a_q[$];
  int               tk;
  int               m_count [NCH];
  logic [NCH-1:0]   m_ovf;
  logic [NCH-1:0]   m_pulse;
  bit               m_vld;
  int               m_ch;
  int               m_cnt;
  int               m_rr;

  logic             cur_en;
  logic [NCH-1:0]   cur_in;
  logic [2*NCH-1:0] cur_mode;
  logic             cur_rdy;
  logic [NCH-1:0]   pulse_acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NCH-1:0] a_at(input int k);
    if (k < 0 || k >= a_q.size()) return '0;
    return a_q[k];
  endfunction

  // A level change applied in cycle k shows as a pulse after edge k+SS+1,
  // provided enable and mode (as applied before that edge) allow it and the
  // edge is past warm-up
  task automatic model_edge();
    int             dec_ch;
    int             dec_v;
    int             base;
    logic [NCH-1:0] o_v;
    logic [NCH-1:0] n_v;
    logic [1:0]     md;
    bit             ev;
    dec_ch = -1;
    dec_v  = 0;
    if (m_vld) begin
      if (evt_rdy) begin
        dec_ch = m_ch;
        dec_v  = m_cnt;
        m_vld  = 1'b0;
        m_rr   = (m_ch + 1) % NCH;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (!m_vld && m_count[(m_rr + i) % NCH] != 0) begin
          m_vld = 1'b1;
          m_ch  = (m_rr + i) % NCH;
          m_cnt = m_count[m_ch];
        end
      end
    end
    o_v = a_at(tk - SS - 2);
    n_v = a_at(tk - SS - 1);
    for (int c = 0; c < NCH; c++) begin
      md = mode[2*c +: 2];
      ev = en && (tk >= SS + 2) &&
           ((md[0] && !o_v[c] && n_v[c]) || (md[1] && o_v[c] && !n_v[c]));
      m_pulse[c] = ev;
      base = m_count[c] - ((c == dec_ch) ? dec_v : 0);
      if (ev && base == MAXC) m_ovf[c] = 1'b1;
      else if (clr_ovf[c]) m_ovf[c] = 1'b0;
      if (ev && base != MAXC) base++;
      m_count[c] = base;
    end
  endtask

  task automatic compare_all();
    check("pulse_out", 32'(pulse_out), 32'(m_pulse));
    check("evt_vld", 32'(evt_vld), 32'(m_vld));
    if (m_vld) begin
      check("evt_ch", 32'(evt_ch), 32'(m_ch));
      check("evt_cnt", 32'(evt_cnt), 32'(m_cnt));
    end
    check("ovf", 32'(ovf), 32'(m_ovf));
  endtask

  // Called at a negedge: apply one cycle of inputs, advance a clock, compare
  task automatic cycle(input logic en_i, input logic [NCH-1:0] in_i,
                       input logic [2*NCH-1:0] mode_i, input logic rdy_i,
                       input logic [NCH-1:0] clr_i);
    en       = en_i;
    async_in = in_i;
    mode     = mode_i;
    evt_rdy  = rdy_i;
    clr_ovf  = clr_i;
    a_q.push_back(in_i);
    @(posedge clk);
    tk++;
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(cur_en, cur_in, cur_mode, cur_rdy, '0);
      pulse_acc |= pulse_out;
    end
  endtask

  task automatic do_reset(input logic [NCH-1:0] in_i);
    rst      = 1'b1;
    async_in = in_i;
    en       = cur_en;
    mode     = cur_mode;
    evt_rdy  = cur_rdy;
    clr_ovf  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    cur_in = in_i;
    a_q.delete();
    tk      = 0;
    m_ovf   = '0;
    m_pulse = '0;
    m_vld   = 1'b0;
    m_ch    = 0;
    m_cnt   = 0;
    m_rr    = 0;
    for (int c = 0; c < NCH; c++) m_count[c] = 0;
    check("rst_pulse", 32'(pulse_out), 32'd0);
    check("rst_vld", 32'(evt_vld), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_ch", 32'(evt_ch), 32'd0);
    check("rst_cnt", 32'(evt_cnt), 32'd0);
  endtask

  initial begin
    int k;
    int hit_t;
    int npulse;
    int order[$];
    bit seen;
    int seen_ch;
    int rdy_pct;

    // 1: input high through reset is not an edge
    cur_en = 1'b1; cur_mode = 8'h55; cur_rdy = 1'b1; pulse_acc = '0;
    do_reset(4'hF);
    run(10);
    check("t1_no_pulse", 32'(pulse_acc), 32'd0);
    check("t1_no_event", 32'(evt_vld), 32'd0);

    // 2: single rise on ch1, latency and first offer
    cur_mode = 8'h04; cur_rdy = 1'b0;
    do_reset(4'h0);
    run(5);
    k = a_q.size();
    cur_in = 4'b0010;
    hit_t = -1; npulse = 0;
    for (int i = 0; i < 8; i++) begin
      run(1);
      if (pulse_out[1]) begin
        npulse++;
        hit_t = tk;
      end
    end
    check("t2_latency", 32'(hit_t), 32'(k + SS + 1));
    check("t2_one_pulse", 32'(npulse), 32'd1);
    check("t2_vld", 32'(evt_vld), 32'd1);
    check("t2_ch", 32'(evt_ch), 32'd1);
    check("t2_cnt", 32'(evt_cnt), 32'd1);
    cur_rdy = 1'b1;
    run(1);
    check("t2_taken", 32'(evt_vld), 32'd0);
    run(3);
    check("t2_drained", 32'(evt_vld), 32'd0);

    // 3: snapshot stays while more edges arrive; remainder offered next
    cur_mode = 8'h03; cur_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cur_in[0] = ~cur_in[0];
      run(2);
    end
    run(4);
    check("t3_ch", 32'(evt_ch), 32'd0);
    check("t3_cnt_first", 32'(evt_cnt), 32'd1);
    cur_rdy = 1'b1;
    run(1);
    cur_rdy = 1'b0;
    run(1);
    check("t3_vld2", 32'(evt_vld), 32'd1);
    check("t3_cnt_rest", 32'(evt_cnt), 32'd4);
    cur_rdy = 1'b1;
    run(4);

    // 4: saturation and overflow on ch2, then clear
    cur_mode = 8'h10; cur_rdy = 1'b0;
    for (int i = 0; i < MAXC + 1; i++) begin
      cur_in[2] = 1'b1; run(2);
      cur_in[2] = 1'b0; run(2);
    end
    run(4);
    check("t4_ovf_set", 32'(ovf[2]), 32'd1);
    check("t4_cnt", 32'(evt_cnt), 32'd1);
    cycle(cur_en, cur_in, cur_mode, cur_rdy, 4'b0100);
    check("t4_ovf_clr", 32'(ovf[2]), 32'd0);
    cur_rdy = 1'b1;
    run(8);

    // 5: round-robin order after reset, then ch0 again
    cur_mode = 8'h55; cur_rdy = 1'b1;
    do_reset(4'h0);
    run(6);
    cur_in = 4'hF;
    for (int i = 0; i < 16; i++) begin
      run(1);
      if (evt_vld) order.push_back(int'(evt_ch));
    end
    check("t5_offers", 32'(order.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < order.size()) check("t5_order", 32'(order[i]), 32'(i));
    end
    cur_in[0] = 1'b0; run(2);
    cur_in[0] = 1'b1;
    seen = 1'b0; seen_ch = -1;
    for (int i = 0; i < 8; i++) begin
      run(1);
      if (evt_vld && !seen) begin
        seen = 1'b1;
        seen_ch = int'(evt_ch);
      end
    end
    check("t5_again_seen", 32'(seen), 32'd1);
    check("t5_again_ch", 32'(seen_ch), 32'd0);

    // 6: toggle while disabled, then reset during an offer
    cur_in[3] = 1'b0; run(5);
    cur_en = 1'b0; cur_in[3] = 1'b1; run(5);
    cur_en = 1'b1; pulse_acc = '0; run(6);
    check("t6_no_pulse", 32'(pulse_acc[3]), 32'd0);
    cur_rdy = 1'b0;
    cur_in[0] = 1'b0; run(3);
    cur_in[0] = 1'b1; run(6);
    check("t6_offer_up", 32'(evt_vld), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_async_drop", 32'(evt_vld), 32'd0);

    // Random: mixed enable, modes, toggles, ready duty and ovf clears
    cur_mode = 8'($urandom);
    do_reset(4'($urandom));
    for (int blk = 0; blk < 8; blk++) begin
      rdy_pct = (blk % 2 == 0) ? 70 : 10;
      for (int i = 0; i < 100; i++) begin
        cur_en = ($urandom_range(0, 9) != 0);
        for (int c = 0; c < NCH; c++) begin
          if ($urandom_range(0, 3) == 0) cur_in[c] = ~cur_in[c];
        end
        if ($urandom_range(0, 15) == 0) cur_mode = 8'($urandom);
        cur_rdy = ($urandom_range(0, 99) < rdy_pct);
        cycle(cur_en, cur_in, cur_mode, cur_rdy,
              ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
